// File: rtl/y86_pkg.sv
// y86_pkg: Y86 icode constants, fetch FSM state type and the icode->length decode.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package y86_pkg;

  localparam int INST_W = 48;

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_NOP    = 4'h1;
  localparam logic [3:0] IC_CMOV   = 4'h2;
  localparam logic [3:0] IC_IRMOVL = 4'h3;
  localparam logic [3:0] IC_RMMOVL = 4'h4;
  localparam logic [3:0] IC_MRMOVL = 4'h5;
  localparam logic [3:0] IC_OPL    = 4'h6;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHL  = 4'hA;
  localparam logic [3:0] IC_POPL   = 4'hB;

  // Register id of %esp.
  localparam logic [3:0] RESP = 4'h4;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

  // Instruction length in bytes; unknown icodes are treated as 1 byte so
  // fetch can step past them.
  function automatic logic [2:0] inst_len(input logic [3:0] icode);
    case (icode)
      IC_HALT, IC_NOP, IC_RET:             inst_len = 3'd1;
      IC_CMOV, IC_OPL, IC_PUSHL, IC_POPL:  inst_len = 3'd2;
      IC_JXX, IC_CALL:                     inst_len = 3'd5;
      IC_IRMOVL, IC_RMMOVL, IC_MRMOVL:     inst_len = 3'd6;
      default:                             inst_len = 3'd1;
    endcase
  endfunction

  function automatic logic icode_ok(input logic [3:0] icode);
    icode_ok = (icode <= IC_POPL);
  endfunction

endpackage

// File: rtl/fetch_byteq.sv
// fetch_byteq: byte shift queue; push 0..4 bytes at the tail, pop 0..6 from the head.
// Latency: push/pop/flush take effect on the next clock; head/count are registered state.
// Backpressure: none internally; the caller must keep pop<=count and count-pop+push<=QBYTES.
//
// Ports: clk, rst (sync, active-high), flush (empties queue, beats push/pop),
//   pop_n, push_n, push_dat (byte k of push at [8k+7:8k]),
//   count (bytes held), head (byte 0 at [47:40] ... byte 5 at [7:0]).
module fetch_byteq
  import y86_pkg::*;
#(
  parameter int QBYTES = 12,
  localparam int CW = $clog2(QBYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [2:0]        pop_n,
  input  logic [2:0]        push_n,
  input  logic [31:0]       push_dat,
  output logic [CW-1:0]     count,
  output logic [INST_W-1:0] head
);

  localparam int QW = 8 * QBYTES;

  // Byte i lives at qv[8i+7:8i]. Bytes at or above count are kept zero, so
  // a pop shifting zeros in from the top and an OR for the push suffices.
  logic [QW-1:0] qv, qv_nxt, shifted, ins;
  logic [31:0]   pdat;
  logic [CW-1:0] base, cnt_nxt;

  always_comb begin
    shifted = qv >> {pop_n, 3'b000};
    pdat    = push_dat & ~(32'hFFFF_FFFF << {push_n, 3'b000});
    base    = count - CW'(pop_n);
    ins     = QW'(pdat) << {base, 3'b000};
    if (flush) begin
      qv_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      qv_nxt  = shifted | ins;
      cnt_nxt = base + CW'(push_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qv    <= '0;
      count <= '0;
    end else begin
      qv    <= qv_nxt;
      count <= cnt_nxt;
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < 6; i++) head[INST_W-1-8*i -: 8] = qv[8*i +: 8];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: Y86 fetch sequencer; owns the PC, reads imem words, presents one instruction per handshake.
// Latency: instruction valid the cycle after the ack completing it; 2 cycles from redirect at 0 wait states.
// Backpressure: inst_ready_i low holds the presented instruction; fetch stops once the byte queue is over QBYTES-4.
//
// Ports: clk, rst (sync, active-high);
//   imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i  word read, req held until ack;
//   inst_valid_o/inst_ready_i/inst_o/pc_o/len_o/inst_invalid_o  instruction out;
//   halted_o  HALT accepted; redirect_i/redirect_pc_i  flush and restart.
module fetch_ctrl
  import y86_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QBYTES   = 12
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [31:0]       imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [31:0]       pc_o,
  output logic [2:0]        len_o,
  output logic              inst_invalid_o,
  output logic              halted_o,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i
);

  localparam int CW = $clog2(QBYTES + 1);

  fetch_state_t      state, state_nxt;
  logic [31:0]       pc, faddr, addr_q, issue_addr, push_dat;
  logic [1:0]        skip;
  logic              req_q, discard;
  logic              present, fire, ack_take, issue;
  logic [CW-1:0]     count;
  logic [INST_W-1:0] head;
  logic [3:0]        head_icode;
  logic [2:0]        head_len, pop_n, push_n;

  assign head_icode = head[INST_W-1 -: 4];
  assign head_len   = inst_len(head_icode);

  fetch_byteq #(.QBYTES(QBYTES)) u_byteq (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_i),
    .pop_n    (pop_n),
    .push_n   (push_n),
    .push_dat (push_dat),
    .count    (count),
    .head     (head)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  // Next state: redirect always restarts fetch; accepting a HALT parks us.
  always_comb begin
    state_nxt = state;
    if (redirect_i)
      state_nxt = ST_FETCH;
    else if (state == ST_FETCH && fire && head_icode == IC_HALT)
      state_nxt = ST_HALT;
  end

  // Outputs and per-cycle control.
  always_comb begin
    present  = (state == ST_FETCH) && (count != '0) && (count >= CW'(head_len));
    fire     = present && inst_ready_i && !redirect_i;
    pop_n    = fire ? head_len : 3'd0;

    // Data of an ack belonging to a pre-redirect request is never pushed.
    ack_take = req_q && imem_ack_i && !discard && !redirect_i;
    push_n   = ack_take ? (3'd4 - {1'b0, skip}) : 3'd0;
    push_dat = imem_rdata_i >> {skip, 3'b000};

    // A redirect with the bus idle issues straight to the new word so the
    // first instruction can be presented two cycles later. Gating on
    // state_nxt keeps a HALT being accepted from starting another read.
    issue_addr = faddr;
    if (redirect_i) begin
      issue      = !req_q;
      issue_addr = {redirect_pc_i[31:2], 2'b00};
    end else begin
      issue = (state_nxt == ST_FETCH) && !req_q && !discard &&
              (count <= CW'(QBYTES - 4));
    end

    inst_valid_o   = present;
    inst_o         = present ? head : '0;
    len_o          = present ? head_len : 3'd0;
    inst_invalid_o = present && !icode_ok(head_icode);
    halted_o       = (state == ST_HALT);
    pc_o           = pc;
    imem_req_o     = req_q;
    imem_addr_o    = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      faddr   <= {RESET_PC[31:2], 2'b00};
      skip    <= RESET_PC[1:0];
      req_q   <= 1'b0;
      addr_q  <= 32'h0;
      discard <= 1'b0;
    end else begin
      if (redirect_i)
        pc <= redirect_pc_i;
      else if (fire)
        pc <= pc + 32'(head_len);

      if (redirect_i) begin
        faddr <= {redirect_pc_i[31:2], 2'b00};
        skip  <= redirect_pc_i[1:0];
      end else if (ack_take) begin
        faddr <= faddr + 32'd4;
        skip  <= 2'd0;
      end

      // Request stays up with a stable address until acked, even across a
      // redirect; only one read is ever outstanding.
      if (issue) begin
        req_q  <= 1'b1;
        addr_q <= issue_addr;
      end else if (req_q && imem_ack_i) begin
        req_q <= 1'b0;
      end

      if (req_q && imem_ack_i)
        discard <= 1'b0;
      else if (redirect_i && req_q)
        discard <= 1'b1;
    end
  end

endmodule
